// File: rtl/byte_arb_pkg.sv
// Shared definitions for the byte arbiter: default parameter values,
// the issue/gap FSM encoding and a ceiling-log2 helper usable in
// constant expressions (port widths, pointer widths).
package byte_arb_pkg;

    localparam int DEF_NUM_CH     = 3;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [0:0] ST_ISSUE = 1'b0;
    localparam logic [0:0] ST_GAP   = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous per-channel byte FIFO with first-word-fall-through read data
// and registered full/empty flags. A write to a full FIFO is still taken
// when a read happens in the same cycle, so occupancy stays at DEPTH.
module byte_fifo
    import byte_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wrEn,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    output logic [DATA_W-1:0] rdData,
    output logic              full,
    output logic              empty
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [PW:0]       count;
    logic [PW:0]       countNext;
    logic              doRead;
    logic              doWrite;

    assign doRead  = rdEn & ~empty;
    assign doWrite = wrEn & (~full | doRead);
    assign rdData  = mem[rdPtr];

    // Next occupancy, used so the flags can be registered alongside the count
    always_comb begin
        countNext = count;
        if (doWrite && !doRead) begin
            countNext = count + 1'b1;
        end else if (!doWrite && doRead) begin
            countNext = count - 1'b1;
        end
    end

    // Storage array; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doRead) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= countNext;
            full  <= (countNext == FULL_CNT);
            empty <= (countNext == '0);
        end
    end

endmodule

// File: rtl/byte_arb_nx1.sv
// N-to-1 byte arbiter: each channel feeds its own byte_fifo, and a two-state
// issue/gap FSM pops at most one byte every other cycle toward a downstream
// sink (e.g. a UART TX) that may stall with busy.
// Build option: define BYTE_ARB_FIXED_PRI_EN for fixed priority (lowest
// channel index wins); otherwise channels are served round-robin.
module byte_arb_nx1
    import byte_arb_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH*DATA_W-1:0]   d,
    input  logic [NUM_CH-1:0]          dv,
    input  logic                       busy,
    input  logic                       ovf_clr,
    output logic [DATA_W-1:0]          od,
    output logic                       odv,
    output logic [clog2(NUM_CH)-1:0]   ogrant,
    output logic [NUM_CH-1:0]          pend,
    output logic [NUM_CH-1:0]          ovf
);

    localparam int GW = clog2(NUM_CH);

    logic [DATA_W-1:0] fifoData [NUM_CH];
    logic [NUM_CH-1:0] fifoFull;
    logic [NUM_CH-1:0] fifoEmpty;
    logic [NUM_CH-1:0] popVec;
    logic [NUM_CH-1:0] dropVec;
    logic [NUM_CH-1:0] eligible;
    logic [0:0]        state;
    logic [GW-1:0]     selIdx;
    logic              hasReq;
    logic              doPop;

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        byte_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) uFifo (
            .clk    (clk),
            .resetn (resetn),
            .wrEn   (dv[i]),
            .wrData (d[i*DATA_W +: DATA_W]),
            .rdEn   (popVec[i]),
            .rdData (fifoData[i]),
            .full   (fifoFull[i]),
            .empty  (fifoEmpty[i])
        );
        assign dropVec[i] = dv[i] & fifoFull[i] & ~popVec[i];
    end

    // A channel competes once pend has caught up and it is still non-empty
    assign eligible = pend & ~fifoEmpty;
    assign hasReq   = |eligible;
    assign doPop    = (state == ST_ISSUE) && !busy && hasReq;

`ifdef BYTE_ARB_FIXED_PRI_EN
    // Fixed priority: the lowest-index eligible channel wins
    always_comb begin
        selIdx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                selIdx = GW'(i);
            end
        end
    end
`else
    logic [GW-1:0] last;

    // Round-robin: the eligible channel closest after last (wrapping) wins
    always_comb begin
        int            cand;
        logic [GW-1:0] candIdx;
        selIdx  = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = int'(last) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            candIdx = GW'(cand);
            if (eligible[candIdx]) begin
                selIdx = candIdx;
            end
        end
    end

    // Remember the most recent grant as the round-robin starting point
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last <= GW'(NUM_CH - 1);
        end else if (doPop) begin
            last <= selIdx;
        end
    end
`endif

    // One-hot pop strobe toward the granted FIFO
    always_comb begin
        popVec = '0;
        if (doPop) begin
            popVec[selIdx] = 1'b1;
        end
    end

    // Issue/gap FSM: every pop is followed by one forced idle cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_ISSUE;
        end else begin
            case (state)
                ST_ISSUE: state <= doPop ? ST_GAP : ST_ISSUE;
                default:  state <= ST_ISSUE;
            endcase
        end
    end

    // Registered output byte, grant index and single-cycle valid pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            od     <= '0;
            ogrant <= '0;
            odv    <= 1'b0;
        end else begin
            odv <= doPop;
            if (doPop) begin
                od     <= fifoData[selIdx];
                ogrant <= selIdx;
            end
        end
    end

    // Pending flags follow FIFO occupancy; overflow flags are sticky, a drop beats a clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= ~fifoEmpty;
            ovf  <= (ovf & ~{NUM_CH{ovf_clr}}) | dropVec;
        end
    end

endmodule

// File: tb/tb_byte_arb_nx1.sv
// Directed self-checking bench for byte_arb_nx1 (NUM_CH=3, DATA_W=8,
// FIFO_DEPTH=4). Expected values are hand-derived; the arbitration-order
// step picks its expected sequence from BYTE_ARB_FIXED_PRI_EN.
module tb_byte_arb_nx1;

    localparam int NUM_CH     = 3;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic                     clk;
    logic                     resetn;
    logic [NUM_CH*DATA_W-1:0] d;
    logic [NUM_CH-1:0]        dv;
    logic                     busy;
    logic                     ovf_clr;
    logic [DATA_W-1:0]        od;
    logic                     odv;
    logic [1:0]               ogrant;
    logic [NUM_CH-1:0]        pend;
    logic [NUM_CH-1:0]        ovf;

    int          testCount;
    int          failCount;
    int          backToBack;
    int          odvSeen;
    logic        prevOdv;
    logic [15:0] outQ [$];
    logic [15:0] expQ [4];

    byte_arb_nx1 #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .d       (d),
        .dv      (dv),
        .busy    (busy),
        .ovf_clr (ovf_clr),
        .od      (od),
        .odv     (odv),
        .ogrant  (ogrant),
        .pend    (pend),
        .ovf     (ovf)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture every emitted byte with its grant and flag back-to-back valids
    always @(negedge clk) begin
        if (resetn && odv) begin
            outQ.push_back({8'(ogrant), od});
            if (prevOdv) begin
                backToBack <= backToBack + 1;
            end
        end
        prevOdv <= odv;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one cycle of write strobes; returns at the next falling edge
    task automatic applyStimulus(input logic [NUM_CH-1:0] dvVal, input logic [NUM_CH*DATA_W-1:0] dVal);
        dv = dvVal;
        d  = dVal;
        @(negedge clk);
        dv = '0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        outQ.delete();
    endtask

    initial begin
        testCount  = 0;
        failCount  = 0;
        backToBack = 0;
        prevOdv    = 1'b0;
        resetn     = 1'b0;
        d          = '0;
        dv         = '0;
        busy       = 1'b0;
        ovf_clr    = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset odv", 32'(odv), 32'h0);
        checkOutput("reset pend", 32'(pend), 32'h0);
        checkOutput("reset ovf", 32'(ovf), 32'h0);
        checkOutput("reset od", 32'(od), 32'h0);
        checkOutput("reset ogrant", 32'(ogrant), 32'h0);
        resetn = 1'b1;
        waitCycles(3);

        // Single byte latency: sampled at edge A, visible after edge A+2
        outQ.delete();
        applyStimulus(3'b001, 24'h000041);
        checkOutput("latency A+0 odv", 32'(odv), 32'h0);
        @(negedge clk);
        checkOutput("latency A+1 odv", 32'(odv), 32'h0);
        checkOutput("latency A+1 pend", 32'(pend), 32'h1);
        @(negedge clk);
        checkOutput("latency A+2 odv", 32'(odv), 32'h1);
        checkOutput("latency A+2 od", 32'(od), 32'h41);
        checkOutput("latency A+2 ogrant", 32'(ogrant), 32'h0);
        @(negedge clk);
        checkOutput("latency A+3 odv", 32'(odv), 32'h0);
        checkOutput("latency A+3 od hold", 32'(od), 32'h41);
        checkOutput("latency A+3 pend", 32'(pend), 32'h0);

        // Round-robin: three simultaneous bytes leave on alternate cycles
        doReset();
        applyStimulus(3'b111, 24'h302010);
        checkOutput("rr A+0 odv", 32'(odv), 32'h0);
        @(negedge clk);
        checkOutput("rr A+1 pend", 32'(pend), 32'h7);
        @(negedge clk);
        checkOutput("rr A+2 odv", 32'(odv), 32'h1);
        checkOutput("rr A+2 od", 32'(od), 32'h10);
        @(negedge clk);
        checkOutput("rr A+3 odv", 32'(odv), 32'h0);
        @(negedge clk);
        checkOutput("rr A+4 odv", 32'(odv), 32'h1);
        checkOutput("rr A+4 od", 32'(od), 32'h20);
        checkOutput("rr A+4 ogrant", 32'(ogrant), 32'h1);
        @(negedge clk);
        checkOutput("rr A+5 odv", 32'(odv), 32'h0);
        @(negedge clk);
        checkOutput("rr A+6 odv", 32'(odv), 32'h1);
        checkOutput("rr A+6 od", 32'(od), 32'h30);
        checkOutput("rr A+6 ogrant", 32'(ogrant), 32'h2);

        // Overflow on channel 1 while busy holds the output off
        doReset();
        busy = 1'b1;
        applyStimulus(3'b010, 24'h000100);
        applyStimulus(3'b010, 24'h000200);
        applyStimulus(3'b010, 24'h000300);
        applyStimulus(3'b010, 24'h000400);
        checkOutput("ovf before drop", 32'(ovf), 32'h0);
        applyStimulus(3'b010, 24'h000500);
        checkOutput("ovf after drop", 32'(ovf), 32'h2);
        checkOutput("ovf pend", 32'(pend), 32'h2);
        odvSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (odv) odvSeen++;
        end
        checkOutput("busy holds odv", 32'(odvSeen), 32'h0);
        busy = 1'b0;
        @(negedge clk);
        checkOutput("busy release odv", 32'(odv), 32'h1);
        waitCycles(8);
        checkOutput("ovf drain count", 32'(outQ.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf drain byte %0d", i), 32'(outQ[i]), 32'h0100 + 32'(i + 1));
        end
        checkOutput("ovf sticky", 32'(ovf), 32'h2);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf cleared", 32'(ovf), 32'h0);

        // A drop coinciding with ovf_clr keeps the flag set
        outQ.delete();
        busy = 1'b1;
        applyStimulus(3'b100, 24'h310000);
        applyStimulus(3'b100, 24'h320000);
        applyStimulus(3'b100, 24'h330000);
        applyStimulus(3'b100, 24'h340000);
        ovf_clr = 1'b1;
        applyStimulus(3'b100, 24'h350000);
        ovf_clr = 1'b0;
        checkOutput("drop wins over clear", 32'(ovf), 32'h4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf ch2 cleared", 32'(ovf), 32'h0);
        busy = 1'b0;
        waitCycles(10);
        checkOutput("full drain count", 32'(outQ.size()), 32'h4);
        checkOutput("full drain last", 32'(outQ[3]), 32'h0234);

        // Arbitration order with ch0 and ch2 each holding two bytes
        doReset();
        busy = 1'b1;
        applyStimulus(3'b101, 24'hC000A0);
        applyStimulus(3'b101, 24'hC100A1);
        busy = 1'b0;
        waitCycles(10);
`ifdef BYTE_ARB_FIXED_PRI_EN
        expQ[0] = 16'h00A0;
        expQ[1] = 16'h00A1;
        expQ[2] = 16'h02C0;
        expQ[3] = 16'h02C1;
`else
        expQ[0] = 16'h00A0;
        expQ[1] = 16'h02C0;
        expQ[2] = 16'h00A1;
        expQ[3] = 16'h02C1;
`endif
        checkOutput("order count", 32'(outQ.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("order byte %0d", i), 32'(outQ[i]), 32'(expQ[i]));
        end

        // Reset mid-operation discards queued bytes
        doReset();
        busy = 1'b1;
        applyStimulus(3'b111, 24'h939291);
        waitCycles(2);
        checkOutput("pre-reset pend", 32'(pend), 32'h7);
        resetn = 1'b0;
        #1;
        checkOutput("async reset pend", 32'(pend), 32'h0);
        checkOutput("async reset odv", 32'(odv), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        busy   = 1'b0;
        outQ.delete();
        waitCycles(10);
        checkOutput("no stale bytes", 32'(outQ.size()), 32'h0);
        applyStimulus(3'b010, 24'h005500);
        waitCycles(4);
        checkOutput("post-reset count", 32'(outQ.size()), 32'h1);
        checkOutput("post-reset byte", 32'(outQ[0]), 32'h0155);

        checkOutput("no back-to-back odv", 32'(backToBack), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/byte_arb_nx1.md
BYTE_ARB_NX1 -- requirements
Module: byte_arb_nx1

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of byte-source channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, width of each channel's data in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per channel FIFO (power of two, 2..64).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port d  input  NUM_CH*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port dv  input  NUM_CH  per-channel one-cycle write strobe.
REQ-008 SHALL have port busy  input  1  downstream busy (e.g. UART TX); no byte issued while high.
REQ-009 SHALL have port ovf_clr  input  1  clears all sticky overflow flags.
REQ-010 SHALL have port od  output  DATA_W  arbitrated data.
REQ-011 SHALL have port odv  output  1  one-cycle valid pulse for od.
REQ-012 SHALL have port ogrant  output  $clog2(NUM_CH)  channel index of the byte on od.
REQ-013 SHALL have port pend  output  NUM_CH  per-channel FIFO non-empty flags.
REQ-014 SHALL have port ovf  output  NUM_CH  per-channel sticky overflow flags.

Function
REQ-015 SHALL push d[i] into FIFO i on any cycle dv[i]=1 and FIFO i not full, all channels independently in the same cycle.
REQ-016 SHALL accept a write to a full FIFO when that FIFO is popped in the same cycle (occupancy unchanged).
REQ-017 SHALL drop a write to a full FIFO not popped that cycle and set ovf[i] on the next edge.
REQ-018 SHALL clear ovf on ovf_clr=1; a drop in the same cycle as ovf_clr SHALL leave that ovf bit set.
REQ-019 SHALL use a two-state FSM: ISSUE (may pop) and GAP (no pop); ISSUE->GAP on a pop, GAP->ISSUE unconditionally.
REQ-020 SHALL pop in ISSUE only when busy=0 and any pend bit is set; odv therefore never high on two consecutive cycles.
REQ-021 SHALL register od, ogrant and odv; odv high exactly one cycle per popped byte, od/ogrant hold their last value otherwise.
REQ-022 SHALL give latency of 2 clocks from dv sampled (empty FIFO, idle FSM, busy=0) to odv high.
REQ-023 SHALL preserve per-channel byte order; no byte duplicated or lost except per REQ-017.
REQ-024 SHALL update pend registered from FIFO occupancy after each edge.
REQ-025 SHALL (round-robin mode) search from channel last+1 upward, wrapping NUM_CH-1 -> 0, and update last to the granted channel.

Reset
REQ-026 SHALL on resetn=0 immediately zero all FIFO pointers/counts, od, ogrant, odv, pend, ovf; FSM to ISSUE; last to NUM_CH-1.
REQ-027 SHALL discard any FIFO contents on reset mid-operation; first post-reset grant in round-robin mode is channel 0.

Configuration
REQ-028 SHALL with BYTE_ARB_FIXED_PRI_EN defined grant the lowest-index non-empty channel (fixed priority, keyboard on channel 0); last unused.
REQ-029 SHALL without BYTE_ARB_FIXED_PRI_EN use round-robin per REQ-025.

Structure
REQ-030 SHALL place default parameter values, FSM state encoding and a ceiling-log2 constant function in package byte_arb_pkg.
REQ-031 SHALL implement each channel FIFO as sub-module byte_fifo (sync, registered full/empty, DATA_W x FIFO_DEPTH), instantiated NUM_CH times.

Verification
REQ-032 SHALL test: dv[0]=1 d=0x41 at cycle 10, busy=0 -> odv=1 od=0x41 ogrant=0 at cycle 12.
REQ-033 SHALL test: NUM_CH=3 round-robin, all dv=1 same cycle with 0x10/0x20/0x30 -> od 0x10,0x20,0x30 on alternate cycles.
REQ-034 SHALL test: FIFO_DEPTH=4, busy=1, 5 writes 0x01..0x05 on ch1 -> ovf[1]=1; release busy -> 0x01..0x04 out; ovf_clr -> ovf=0.
REQ-035 SHALL test: busy held high 20 cycles with pend!=0 -> odv stays 0; busy low -> odv within 2 cycles.
REQ-036 SHALL test: BYTE_ARB_FIXED_PRI_EN, ch0 and ch2 each hold 2 bytes -> both ch0 bytes precede ch2 bytes.
REQ-037 SHALL test: resetn low for 1 cycle with 3 bytes queued -> pend=0, odv=0, no stale byte emitted afterwards.
